wb_arbiter_2to1: RTL

//  Merges the core's instruction bus and data bus, both classic Wishbone, onto one single-port

---
 rtl/wb_arbiter_2to1.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/wb_arbiter_2to1.sv
// Two classic Wishbone masters (instruction, data) merged onto one single-port slave, round-robin.
// Latency: 1 cycle from master request to slave cyc; no direct handover, one IDLE cycle between grants.
// Backpressure: the losing master simply sees no ack until granted; watchdog forces err on a dead slave.
module wb_arbiter_2to1 #(
  parameter int unsigned TIMEOUT = 32'd255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] iwbs_addr_i,
  input  logic        iwbs_cyc_i,
  input  logic        iwbs_stb_i,
  output logic [31:0] iwbs_dat_o,
  output logic        iwbs_ack_o,
  output logic        iwbs_err_o,
  input  logic [31:0] dwbs_addr_i,
  input  logic [31:0] dwbs_dat_i,
  input  logic [3:0]  dwbs_sel_i,
  input  logic        dwbs_cyc_i,
  input  logic        dwbs_stb_i,
  input  logic        dwbs_we_i,
  output logic [31:0] dwbs_dat_o,
  output logic        dwbs_ack_o,
  output logic        dwbs_err_o,
  output logic [31:0] wbm_addr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
  } wb_req_t;

  state_t  state;
  logic    last_gnt_d;   // 0: instruction master owned the bus last, 1: data master
  logic    req_i;
  logic    req_d;
  logic    gnt_i;
  logic    gnt_d;
  logic    granted;
  logic    timeout_hit;
  logic    err_raw;
  wb_req_t ireq;
  wb_req_t dreq;
  wb_req_t sel_req;

  assign req_i   = iwbs_cyc_i & iwbs_stb_i;
  assign req_d   = dwbs_cyc_i & dwbs_stb_i;
  assign gnt_i   = (state == GNT_I);
  assign gnt_d   = (state == GNT_D);
  assign granted = gnt_i | gnt_d;

  // Instruction fetches are always full-word reads.
  assign ireq = '{addr: iwbs_addr_i, dat: 32'h0, sel: 4'hF, we: 1'b0,
                  cyc: iwbs_cyc_i, stb: iwbs_stb_i};
  assign dreq = '{addr: dwbs_addr_i, dat: dwbs_dat_i, sel: dwbs_sel_i, we: dwbs_we_i,
                  cyc: dwbs_cyc_i, stb: dwbs_stb_i};

  always_comb begin
    sel_req = '0;
    case (state)
      GNT_I:   sel_req = ireq;
      GNT_D:   sel_req = dreq;
      default: sel_req = '0;
    endcase
  end

  assign wbm_addr_o = sel_req.addr;
  assign wbm_dat_o  = sel_req.dat;
  assign wbm_sel_o  = sel_req.sel;
  assign wbm_we_o   = sel_req.we;
  assign wbm_cyc_o  = sel_req.cyc;
  assign wbm_stb_o  = sel_req.stb & ~timeout_hit;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      last_gnt_d <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_i && req_d)
            state <= last_gnt_d ? GNT_I : GNT_D;
          else if (req_d)
            state <= GNT_D;
          else if (req_i)
            state <= GNT_I;
        end
        GNT_I: begin
          if (!iwbs_cyc_i) begin
            state      <= IDLE;
            last_gnt_d <= 1'b0;
          end
        end
        GNT_D: begin
          if (!dwbs_cyc_i) begin
            state      <= IDLE;
            last_gnt_d <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  generate
    if (TIMEOUT != 0) begin : g_wdog
      localparam int WDW = $clog2(TIMEOUT + 1);
      logic [WDW-1:0] wdog;
      logic           wdog_run;

      // Restarts on every ack/err, so each strobe of a multi-strobe cycle gets its own budget.
      assign wdog_run = granted & wbm_stb_o & ~wbm_ack_i & ~wbm_err_i;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
          wdog <= '0;
        else if (wdog_run)
          wdog <= wdog + 1'b1;
        else
          wdog <= '0;
      end

      assign timeout_hit = granted & (wdog == WDW'(TIMEOUT));
    end else begin : g_no_wdog
      assign timeout_hit = 1'b0;
    end
  endgenerate

  // A late slave ack on the timeout cycle still completes the access normally.
  assign err_raw = wbm_err_i | (timeout_hit & ~wbm_ack_i);

  assign iwbs_ack_o = gnt_i & wbm_ack_i;
  assign iwbs_err_o = gnt_i & err_raw;
  assign dwbs_ack_o = gnt_d & wbm_ack_i;
  assign dwbs_err_o = gnt_d & err_raw;

  assign iwbs_dat_o = wbm_dat_i;
  assign dwbs_dat_o = wbm_dat_i;

endmodule
